// File: rtl/pico_key_input_if.sv
// CPU-side read bus of the PICO16a key/switch input peripheral.
// The CPU is the master. The peripheral is the slave.
interface pico_key_input_if;
  logic [1:0]  addr;
  logic        rd;
  logic [15:0] rdata;
  logic        irq;

  modport master (output addr, output rd, input rdata, input irq);
  modport slave  (input addr, input rd, output rdata, output irq);
endinterface

// File: rtl/pico_key_input.sv
// PICO16a input peripheral: synchronised switches, debounced push buttons,
// clear-on-read press events and a level interrupt while any press is pending.
module pico_key_input #(
  parameter  int DEBOUNCE_CYCLES = 16,
  localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       key_n,
  input  logic [17:0]      sw,
  pico_key_input_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       key_meta_r;
  logic [3:0]       key_sync_r;
  logic [17:0]      sw_meta_r;
  logic [17:0]      sw_sync_r;
  logic [3:0]       key_state_r;
  logic [CNT_W-1:0] cnt_r [4];
  logic [3:0]       evt_r;
  logic [15:0]      rdata_r;
  logic             irq_r;

  logic [3:0]       key_pressed_s;
  logic [3:0]       state_next_s;
  logic [CNT_W-1:0] cnt_next_s [4];
  logic [3:0]       press_s;
  logic             clear_s;
  logic [3:0]       evt_next_s;
  logic [15:0]      read_mux_s;

  // Debounce, press detection, event update and read-data selection.
  always_comb begin
    key_pressed_s = ~key_sync_r;
    for (int k = 0; k < 4; k++) begin
      state_next_s[k] = key_state_r[k];
      cnt_next_s[k]   = cnt_r[k];
      if (key_pressed_s[k] == key_state_r[k]) begin
        cnt_next_s[k] = CNT_ZERO;
      end else if (cnt_r[k] == CNT_LAST) begin
        state_next_s[k] = key_pressed_s[k];
        cnt_next_s[k]   = CNT_ZERO;
      end else begin
        cnt_next_s[k] = cnt_r[k] + CNT_ONE;
      end
    end

    press_s = state_next_s & ~key_state_r;
    clear_s = bus.rd && (bus.addr == 2'd1);
    // A press on the clearing edge survives the clear.
    if (clear_s) begin
      evt_next_s = press_s;
    end else begin
      evt_next_s = evt_r | press_s;
    end

    case (bus.addr)
      2'd0:    read_mux_s = {12'h000, key_state_r};
      2'd1:    read_mux_s = {12'h000, evt_r};
      2'd2:    read_mux_s = sw_sync_r[15:0];
      2'd3:    read_mux_s = {14'h0000, sw_sync_r[17:16]};
      default: read_mux_s = 16'h0000;
    endcase
  end

  // All state, including the synchronisers and the registered bus outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_meta_r  <= 4'hF;
      key_sync_r  <= 4'hF;
      sw_meta_r   <= 18'h00000;
      sw_sync_r   <= 18'h00000;
      key_state_r <= 4'h0;
      for (int k = 0; k < 4; k++) begin
        cnt_r[k] <= CNT_ZERO;
      end
      evt_r       <= 4'h0;
      rdata_r     <= 16'h0000;
      irq_r       <= 1'b0;
    end else begin
      key_meta_r  <= key_n;
      key_sync_r  <= key_meta_r;
      sw_meta_r   <= sw;
      sw_sync_r   <= sw_meta_r;
      key_state_r <= state_next_s;
      for (int k = 0; k < 4; k++) begin
        cnt_r[k] <= cnt_next_s[k];
      end
      evt_r       <= evt_next_s;
      irq_r       <= |evt_next_s;
      if (bus.rd) begin
        rdata_r <= read_mux_s;
      end else begin
        rdata_r <= rdata_r;
      end
    end
  end

  assign bus.rdata = rdata_r;
  assign bus.irq   = irq_r;

endmodule

// File: tb/tb_pico_key_input.sv
// Directed and randomized checks of pico_key_input against a cycle-level behavioural model.
module tb_pico_key_input;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  key_n;
  logic [17:0] sw;
  int          n_cmp = 0;
  int          n_bad = 0;

  pico_key_input_if bus ();

  pico_key_input #(.DEBOUNCE_CYCLES(D)) dut (
    .clk   (clk),
    .reset (reset),
    .key_n (key_n),
    .sw    (sw),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Model: inputs delayed by two samples, accepted level, run length of disagreement.
  logic [3:0]  mk_new, mk_old;
  logic [17:0] ms_new, ms_old;
  logic [3:0]  m_state, m_evt;
  int          m_run [4];
  logic [15:0] m_rdata;
  logic        m_irq;

  task automatic model_edge();
    logic [3:0]  seen, nstate, press;
    if (reset) begin
      mk_new = 4'hF; mk_old = 4'hF; ms_new = 18'h0; ms_old = 18'h0;
      m_state = 4'h0; m_evt = 4'h0; m_rdata = 16'h0; m_irq = 1'b0;
      for (int k = 0; k < 4; k++) m_run[k] = 0;
    end else begin
      seen   = ~mk_old;
      nstate = m_state;
      for (int k = 0; k < 4; k++) begin
        if (seen[k] != m_state[k]) begin
          m_run[k] = m_run[k] + 1;
          if (m_run[k] == D) begin
            nstate[k] = seen[k];
            m_run[k]  = 0;
          end
        end else begin
          m_run[k] = 0;
        end
      end
      press = nstate & ~m_state;
      if (bus.rd) begin
        case (bus.addr)
          2'd0: m_rdata = {12'h0, m_state};
          2'd1: m_rdata = {12'h0, m_evt};
          2'd2: m_rdata = ms_old[15:0];
          default: m_rdata = {14'h0, ms_old[17:16]};
        endcase
      end
      if (bus.rd && bus.addr == 2'd1) m_evt = press;
      else m_evt = m_evt | press;
      m_irq   = |m_evt;
      m_state = nstate;
      mk_old = mk_new; mk_new = key_n;
      ms_old = ms_new; ms_new = sw;
    end
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("model_irq", {15'h0, bus.irq}, {15'h0, m_irq});
    check("model_rdata", bus.rdata, m_rdata);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic read_reg(input logic [1:0] a, input string tag, input logic [15:0] exp);
    bus.addr = a; bus.rd = 1'b1;
    step();
    bus.rd = 1'b0;
    check(tag, bus.rdata, exp);
  endtask

  initial begin
    reset = 1'b1; key_n = 4'hF; sw = 18'h0; bus.rd = 1'b0; bus.addr = 2'd0;
    steps(3);
    check("reset_rdata", bus.rdata, 16'h0000);
    check("reset_irq", {15'h0, bus.irq}, 16'h0000);
    reset = 1'b0;
    steps(2);
    for (int a = 0; a < 4; a++) read_reg(2'(a), "reset_reg", 16'h0000);
    steps(4);
    check("no_evt_after_reset", {15'h0, bus.irq}, 16'h0000);

    // Clean press of key 0: accepted on the sixth edge.
    key_n = 4'hE;
    steps(5);
    check("press0_early_irq", {15'h0, bus.irq}, 16'h0000);
    step();
    check("press0_irq", {15'h0, bus.irq}, 16'h0001);
    read_reg(2'd0, "press0_state", 16'h0001);
    read_reg(2'd1, "press0_evt", 16'h0001);
    check("press0_irq_cleared", {15'h0, bus.irq}, 16'h0000);
    read_reg(2'd1, "press0_reread", 16'h0000);
    key_n = 4'hF;
    steps(8);
    check("release0_no_irq", {15'h0, bus.irq}, 16'h0000);
    read_reg(2'd0, "release0_state", 16'h0000);

    // Short glitch on key 1 is rejected.
    key_n = 4'hD;
    steps(3);
    key_n = 4'hF;
    steps(8);
    check("glitch_irq", {15'h0, bus.irq}, 16'h0000);
    read_reg(2'd0, "glitch_state", 16'h0000);
    read_reg(2'd1, "glitch_evt", 16'h0000);

    // Press of key 2 landing on the clearing read edge stays pending.
    key_n = 4'hB;
    steps(5);
    bus.addr = 2'd1; bus.rd = 1'b1;
    step();
    bus.rd = 1'b0;
    check("race_rdata", bus.rdata, 16'h0000);
    check("race_irq", {15'h0, bus.irq}, 16'h0001);
    read_reg(2'd1, "race_pending", 16'h0004);
    check("race_irq_cleared", {15'h0, bus.irq}, 16'h0000);
    key_n = 4'hF;
    steps(8);

    // Switch readback.
    sw = 18'h2A5A5;
    steps(3);
    read_reg(2'd2, "sw_low", 16'hA5A5);
    read_reg(2'd3, "sw_high", 16'h0002);

    // Reset with an event pending and another key mid-debounce.
    key_n = 4'h7;
    steps(6);
    check("pre_reset_irq", {15'h0, bus.irq}, 16'h0001);
    key_n = 4'h6;
    steps(4);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_reset_irq", {15'h0, bus.irq}, 16'h0000);
    check("mid_reset_rdata", bus.rdata, 16'h0000);
    steps(5);
    check("repress_early_irq", {15'h0, bus.irq}, 16'h0000);
    step();
    check("repress_irq", {15'h0, bus.irq}, 16'h0001);
    read_reg(2'd1, "repress_multi_evt", 16'h0009);
    key_n = 4'hF;
    steps(8);
    read_reg(2'd1, "release_no_evt", 16'h0000);

    // Random phase: bouncy keys, switch changes, random reads and rare resets.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) key_n = 4'($urandom);
      if ($urandom_range(0, 29) == 0) sw = 18'($urandom);
      bus.rd   = ($urandom_range(0, 3) == 0);
      bus.addr = 2'($urandom);
      reset    = ($urandom_range(0, 299) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
